// File: rtl/johnson_phase_gen.sv
// johnson_phase_gen
//   W-bit twisted-ring (Johnson) / ring phase generator with enable,
//   direction control, mode select, synchronous phase load, self-correction
//   of illegal states and a binary phase index kept in step with the pattern.
//
// Parameters
//   W        register width, 2..16
//   PHASE_W  width of the phase index, $clog2(2*W)
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst_n       synchronous reset, asserted high (name kept from the codebase)
//   en          advance one phase this cycle
//   dir         0 = forward (shift right), 1 = reverse (shift left)
//   mode        0 = Johnson (period 2W), 1 = ring / one-hot (period W)
//   load        load load_phase this cycle
//   load_phase  target phase for load
//   out         counter pattern
//   phase       binary index of the current pattern
//   wrap        one-cycle pulse after a step across the period boundary
//   err         sticky flag: illegal state corrected or out-of-range load
module johnson_phase_gen #(
    parameter  int unsigned W       = 4,
    localparam int unsigned PHASE_W = $clog2(2 * W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic               mode,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_phase,
    output logic [W-1:0]       out,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               err
);

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    // Action taken this cycle, in priority order below reset.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_MODE,
        ACT_FIX,
        ACT_LOAD,
        ACT_STEP
    } act_e;

    localparam logic [PHASE_W-1:0] LAST_JOHN = PHASE_W'(2 * W - 1);
    localparam logic [PHASE_W-1:0] LAST_RING = PHASE_W'(W - 1);

    // Pattern belonging to phase k.
    //   Johnson: k <= W -> top k bits set; k > W -> low (2W-k) bits set.
    //   Ring:    single bit at position (W-k) mod W.
    function automatic logic [W-1:0] phase_pattern(input logic [PHASE_W-1:0] k,
                                                   input mode_e               m);
        int unsigned  kk;
        logic [W-1:0] p;
        kk = 32'(k);
        p  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (m == MODE_RING) begin
                if (i == (W - (kk % W)) % W) p[i] = 1'b1;
            end else if (kk <= W) begin
                if (i + kk >= W) p[i] = 1'b1;
            end else begin
                if (i + kk < 2 * W) p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    // Johnson patterns are exactly those with at most one 0/1 boundary
    // along the register; ring patterns are exactly one-hot.
    function automatic logic pattern_legal(input logic [W-1:0] v,
                                           input mode_e        m);
        int unsigned ones;
        int unsigned edges;
        ones  = 0;
        edges = 0;
        for (int unsigned i = 0; i < W; i++) begin
            ones += 32'(v[i]);
        end
        for (int unsigned i = 0; i + 1 < W; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        if (m == MODE_RING) return (ones == 1);
        return (edges <= 1);
    endfunction

    mode_e              mode_q;
    logic [W-1:0]       out_q,   out_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q,  wrap_d;
    logic               err_q,   err_d;

    act_e               action;
    logic [PHASE_W-1:0] last_phase;
    logic               illegal;
    logic               load_oor;
    logic [PHASE_W-1:0] load_tgt;

    always_comb begin
        last_phase = (mode_q == MODE_RING) ? LAST_RING : LAST_JOHN;
    end

    // Beyond a malformed pattern, a legal pattern that disagrees with the
    // phase index (or an index past the period) is also treated as an
    // upset, so out and phase can never drift apart.
    always_comb begin
        illegal = !pattern_legal(out_q, mode_q)
                  || (phase_q > last_phase)
                  || (out_q != phase_pattern(phase_q, mode_q));
    end

    always_comb begin
        load_oor = (load_phase > last_phase);
        load_tgt = load_oor ? '0 : load_phase;
    end

    always_comb begin
        action = ACT_HOLD;
        if (mode != logic'(mode_q)) begin
            action = ACT_MODE;
        end else if (illegal) begin
            action = ACT_FIX;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (en) begin
            action = ACT_STEP;
        end
    end

    always_comb begin
        out_d   = out_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        unique case (action)
            ACT_MODE: begin
                out_d   = phase_pattern('0, mode_e'(mode));
                phase_d = '0;
            end
            ACT_FIX: begin
                out_d   = phase_pattern('0, mode_q);
                phase_d = '0;
                err_d   = 1'b1;
            end
            ACT_LOAD: begin
                out_d   = phase_pattern(load_tgt, mode_q);
                phase_d = load_tgt;
                if (load_oor) err_d = 1'b1;
            end
            ACT_STEP: begin
                if (!dir) begin
                    // Forward: shift right, feed MSB from (inverted) LSB.
                    if (mode_q == MODE_RING) out_d = {out_q[0], out_q[W-1:1]};
                    else                     out_d = {~out_q[0], out_q[W-1:1]};
                    if (phase_q == last_phase) begin
                        phase_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end else begin
                    // Reverse: shift left, feed LSB from (inverted) MSB.
                    if (mode_q == MODE_RING) out_d = {out_q[W-2:0], out_q[W-1]};
                    else                     out_d = {out_q[W-2:0], ~out_q[W-1]};
                    if (phase_q == '0) begin
                        phase_d = last_phase;
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mode_q  <= mode_e'(mode);
            out_q   <= phase_pattern('0, mode_e'(mode));
            phase_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mode_q  <= mode_e'(mode);
            out_q   <= out_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_johnson_phase_gen.sv
// tb_johnson_phase_gen
//   Directed bench for johnson_phase_gen at W=4: Johnson forward/reverse
//   with wrap, ring mode, mode switching, in-range and out-of-range loads,
//   recovery from a deposited illegal pattern, reset priority and hold.
module tb_johnson_phase_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          dir;
    logic          mode;
    logic          load;
    logic [PW-1:0] load_phase;
    logic [W-1:0]  out;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;

    int checks = 0;
    int errors = 0;

    johnson_phase_gen #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
        .mode       (mode),
        .load       (load),
        .load_phase (load_phase),
        .out        (out),
        .phase      (phase),
        .wrap       (wrap),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [W-1:0] eo,
                                input logic [PW-1:0] ep, input logic ew, input logic ee);
        chk({tag, ".out"},   32'(out),   32'(eo));
        chk({tag, ".phase"}, 32'(phase), 32'(ep));
        chk({tag, ".wrap"},  32'(wrap),  32'(ew));
        chk({tag, ".err"},   32'(err),   32'(ee));
    endtask

    // Johnson forward sequence after reset, phases 1..7 then 0.
    logic [W-1:0] fwd_out [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                  4'b0111, 4'b0011, 4'b0001, 4'b0000};

    initial begin
        rst_n = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0;
        load = 1'b0; load_phase = '0;
        tick();
        tick();
        expect_state("reset", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Johnson forward through one full period
        rst_n = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_state($sformatf("jfwd%0d", i), fwd_out[i], 3'((i + 1) % 8),
                         (i == 7), 1'b0);
        end
        tick();
        expect_state("jfwd_after_wrap", 4'b1000, 3'd1, 1'b0, 1'b0);
        tick();
        expect_state("jfwd_p2", 4'b1100, 3'd2, 1'b0, 1'b0);

        // Reverse from phase 2, wrap on 0 -> 7, then forward again
        dir = 1'b1;
        tick(); expect_state("jrev1", 4'b1000, 3'd1, 1'b0, 1'b0);
        tick(); expect_state("jrev2", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick(); expect_state("jrev3", 4'b0001, 3'd7, 1'b1, 1'b0);
        dir = 1'b0;
        tick(); expect_state("jfwd_from7", 4'b0000, 3'd0, 1'b1, 1'b0);

        // Ring mode from reset
        en = 1'b0; mode = 1'b1; rst_n = 1'b1;
        tick(); expect_state("ring_reset", 4'b0001, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0; en = 1'b1;
        tick(); expect_state("ring1", 4'b1000, 3'd1, 1'b0, 1'b0);
        tick(); expect_state("ring2", 4'b0100, 3'd2, 1'b0, 1'b0);
        tick(); expect_state("ring3", 4'b0010, 3'd3, 1'b0, 1'b0);
        tick(); expect_state("ring_wrap", 4'b0001, 3'd0, 1'b1, 1'b0);
        tick(); expect_state("ring5", 4'b1000, 3'd1, 1'b0, 1'b0);

        // Mode change mid-run overrides en
        mode = 1'b0;
        tick(); expect_state("mode_to_j", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick(); expect_state("j_after_mode", 4'b1000, 3'd1, 1'b0, 1'b0);
        mode = 1'b1;
        tick(); expect_state("mode_to_r", 4'b0001, 3'd0, 1'b0, 1'b0);
        dir = 1'b1;
        tick(); expect_state("ring_rev_wrap", 4'b0010, 3'd3, 1'b1, 1'b0);
        dir = 1'b0; en = 1'b0; mode = 1'b0;
        tick(); expect_state("back_to_j", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Load beats en
        load = 1'b1; load_phase = 3'd5; en = 1'b1;
        tick(); expect_state("load5", 4'b0111, 3'd5, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0;

        // Out-of-range load only reachable in ring mode at W=4
        mode = 1'b1;
        tick(); expect_state("mode_r2", 4'b0001, 3'd0, 1'b0, 1'b0);
        load = 1'b1; load_phase = 3'd2;
        tick(); expect_state("rload2", 4'b0100, 3'd2, 1'b0, 1'b0);
        load_phase = 3'd6;
        tick(); expect_state("rload_oor", 4'b0001, 3'd0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        tick(); expect_state("err_sticky_step", 4'b1000, 3'd1, 1'b0, 1'b1);
        mode = 1'b0;
        tick(); expect_state("err_sticky_mode", 4'b0000, 3'd0, 1'b0, 1'b1);
        en = 1'b0; rst_n = 1'b1;
        tick(); expect_state("err_clear", 4'b0000, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;

        // Illegal pattern deposited into the register
        force dut.out_q = 4'b0101;
        #1;
        release dut.out_q;
        tick(); expect_state("fix", 4'b0000, 3'd0, 1'b0, 1'b1);
        tick(); expect_state("fix_hold", 4'b0000, 3'd0, 1'b0, 1'b1);

        // Reset beats load and en
        en = 1'b1;
        tick(); tick();
        expect_state("pre_reset", 4'b1100, 3'd2, 1'b0, 1'b1);
        rst_n = 1'b1; load = 1'b1; load_phase = 3'd3;
        tick(); expect_state("reset_wins", 4'b0000, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0; load = 1'b0;
        tick(); tick(); tick();
        expect_state("pre_hold", 4'b1110, 3'd3, 1'b0, 1'b0);

        // Hold with en low while other inputs wiggle
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dir = ~dir;
            load_phase = 3'(i);
            tick();
            expect_state($sformatf("hold%0d", i), 4'b1110, 3'd3, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
